// File: rtl/mem_bus_copier_pkg.sv
// Shared types and constants for the memory bus block copier.
// FSM state encoding, write-strobe patterns and word size.
package mem_bus_copier_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } state_t;

  localparam logic [3:0]  WSTRB_READ = 4'b0000;
  localparam logic [3:0]  WSTRB_WORD = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_bus_copier.sv
// Block copier mastering the picorv32 native memory bus.
// Ports: start/busy/done/error control, words_done, mem_* bus.
module mem_bus_copier
  import mem_bus_copier_pkg::*;
#(
  parameter int          LEN_W          = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  state_t           state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [31:0]      wait_cnt;
  logic [LEN_W-1:0] len_q;
  logic             timeout_hit;

  assign mem_instr = 1'b0;

  // Abort on the cycle the count would reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      wait_cnt   <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_done <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= WSTRB_READ;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q      <= {src_addr[31:2], 2'b00};
            dst_q      <= {dst_addr[31:2], 2'b00};
            len_q      <= len;
            error      <= 1'b0;
            words_done <= '0;
            busy       <= 1'b1;
            wait_cnt   <= '0;
            if (len == '0) begin
              state <= S_FIN;
            end else begin
              state     <= S_RD;
              mem_valid <= 1'b1;
              mem_addr  <= {src_addr[31:2], 2'b00};
              mem_wstrb <= WSTRB_READ;
            end
          end
        end
        S_RD: begin
          if (mem_ready) begin
            data_q    <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= S_RD_GAP;
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RD_GAP: begin
          mem_valid <= 1'b1;
          mem_addr  <= dst_q;
          mem_wdata <= data_q;
          mem_wstrb <= WSTRB_WORD;
          wait_cnt  <= '0;
          state     <= S_WR;
        end
        S_WR: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            words_done <= words_done + 1'b1;
            src_q      <= src_q + WORD_BYTES;
            dst_q      <= dst_q + WORD_BYTES;
            state      <= S_WR_GAP;
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WR_GAP: begin
          if (words_done == len_q) begin
            state <= S_FIN;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= src_q;
            mem_wstrb <= WSTRB_READ;
            wait_cnt  <= '0;
            state     <= S_RD;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_copier.sv
// Self-checking bench for mem_bus_copier.
// Vector table plus timeout, start-while-busy and reset sequences.
module tb_mem_bus_copier;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] words_done;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  mem_bus_copier #(
    .LEN_W(12),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .error(error),
    .words_done(words_done),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rd_log [$];

  int          dly_cnt     = -1;
  bit          rand_mode   = 1'b0;
  int          hang_at     = -1;
  int          acc_cnt     = 0;
  int          hang_cycles = 0;
  int          starts      = 0;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  function automatic logic [31:0] pat(input int v, input int i);
    return 32'hC0DE_0000 + 32'(v * 256 + i);
  endfunction

  // Responder: ready after a per-transfer delay, never for hang_at.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        mem_ready = 1'b0;
        dly_cnt   = -1;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        dly_cnt   = -1;
      end else if (!mem_valid) begin
        dly_cnt = -1;
      end else begin
        if (dly_cnt < 0) begin
          starts++;
          h_addr  = mem_addr;
          h_wdata = mem_wdata;
          h_wstrb = mem_wstrb;
          dly_cnt = rand_mode ? int'($urandom_range(0, 7)) : 1;
        end else begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, h_wstrb});
          if (h_wstrb == 4'hF)
            chk("hold_wdata", mem_wdata, h_wdata);
        end
        if (acc_cnt == hang_at) begin
          hang_cycles++;
        end else if (dly_cnt == 0) begin
          if (mem_wstrb == 4'hF) begin
            mem[widx(mem_addr)] = mem_wdata;
          end else begin
            mem_rdata = mem[widx(mem_addr)];
            rd_log.push_back(mem_addr);
          end
          mem_ready = 1'b1;
          acc_cnt++;
        end else begin
          dly_cnt--;
        end
      end
    end
  end

  task automatic prep(input logic [31:0] s, input logic [31:0] d,
                      input int l, input int v);
    logic [31:0] sa;
    logic [31:0] da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < l; i++)
      mem[widx(sa + 32'(4 * i))] = pat(v, i);
    for (int i = 0; i <= l; i++)
      mem[widx(da + 32'(4 * i))] = 32'hDEAD_BEEF;
    rd_log.delete();
    starts = 0;
  endtask

  task automatic chk_dst(input logic [31:0] d, input int l, input int v);
    logic [31:0] da;
    da = {d[31:2], 2'b00};
    for (int i = 0; i < l; i++)
      chk("dst_data", mem[widx(da + 32'(4 * i))], pat(v, i));
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                         input logic [11:0] l, input int poke_at,
                         output int n);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && n < 3000) begin
      if (n == poke_at) begin
        src_addr = 32'h0;
        dst_addr = 32'h3F0;
        len      = 12'd1;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL done_wait: got no done after %0d cycles", n);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    bit          rnd;
    int          cyc;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    tbl[0] = '{32'h0000_0100, 32'h0000_0200, 4, 1'b0, 26,
               32'h0000_0100, 32'h0000_0104};
    tbl[1] = '{32'h0000_0000, 32'h0000_0000, 0, 1'b0, 2,
               32'h0, 32'h0};
    tbl[2] = '{32'h0000_00A2, 32'h0000_035F, 1, 1'b0, 8,
               32'h0000_00A0, 32'h0};
    tbl[3] = '{32'h0000_0140, 32'h0000_0240, 6, 1'b1, -1,
               32'h0000_0140, 32'h0000_0144};
    tbl[4] = '{32'hFFFF_FFFE, 32'h0000_0300, 2, 1'b0, 14,
               32'hFFFF_FFFC, 32'h0000_0000};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    resetn   = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_words", {20'd0, words_done}, 32'd0);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_instr", {31'd0, mem_instr}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      prep(tbl[v].src, tbl[v].dst, tbl[v].len, v);
      rand_mode = tbl[v].rnd;
      run_job(tbl[v].src, tbl[v].dst, 12'(tbl[v].len), -1, n);
      if (tbl[v].cyc >= 0) chk("latency", n, tbl[v].cyc);
      chk("error", {31'd0, error}, 32'd0);
      chk("words_done", {20'd0, words_done}, tbl[v].len);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("valid_starts", starts, 2 * tbl[v].len);
      chk_dst(tbl[v].dst, tbl[v].len, v);
      chk("rd_count", rd_log.size(), tbl[v].len);
      if (tbl[v].len > 0 && rd_log.size() > 0)
        chk("rd0_addr", rd_log[0], tbl[v].rd0);
      if (tbl[v].len > 1 && rd_log.size() > 1)
        chk("rd1_addr", rd_log[1], tbl[v].rd1);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
    end
    rand_mode = 1'b0;

    // Timeout: third read never answered.
    prep(32'h0, 32'h3A0, 5, 7);
    acc_cnt     = 0;
    hang_cycles = 0;
    hang_at     = 4;
    run_job(32'h0, 32'h3A0, 12'd5, -1, n);
    chk("to_latency", n, 22);
    chk("to_error", {31'd0, error}, 32'd1);
    chk("to_words", {20'd0, words_done}, 32'd2);
    chk("to_valid_cycles", hang_cycles, 8);
    chk("to_valid", {31'd0, mem_valid}, 32'd0);
    chk_dst(32'h3A0, 2, 7);
    chk("to_untouched", mem[widx(32'h3A8)], 32'hDEAD_BEEF);
    hang_at = -1;
    @(posedge clk);
    #1;
    chk("to_error_held", {31'd0, error}, 32'd1);

    // Second start while busy must be ignored.
    prep(32'h180, 32'h2C0, 3, 8);
    run_job(32'h180, 32'h2C0, 12'd3, 4, n);
    chk("sb_latency", n, 20);
    chk("sb_error_clr", {31'd0, error}, 32'd0);
    chk("sb_words", {20'd0, words_done}, 32'd3);
    chk_dst(32'h2C0, 3, 8);
    @(posedge clk);
    #1;

    // Reset in the middle of a write.
    prep(32'h180, 32'h2C0, 3, 9);
    src_addr = 32'h180;
    dst_addr = 32'h2C0;
    len      = 12'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 0;
    while (!(mem_valid && mem_wstrb == 4'hF) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rs_saw_write", {31'd0, mem_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_valid", {31'd0, mem_valid}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_words", {20'd0, words_done}, 32'd0);
    chk("rs_wstrb", {28'd0, mem_wstrb}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    prep(32'h1C0, 32'h340, 2, 10);
    run_job(32'h1C0, 32'h340, 12'd2, -1, n);
    chk("ar_latency", n, 14);
    chk("ar_words", {20'd0, words_done}, 32'd2);
    chk("ar_error", {31'd0, error}, 32'd0);
    chk_dst(32'h340, 2, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
